// File: rtl/fetch_pkg.sv
// Shared constants and state type for the MIPS instruction fetch stage.
package fetch_pkg;

   localparam logic [5:0]  OPCODE_HALT = 6'b111111;
   localparam logic [31:0] INSTR_NOP   = 32'h0;
   localparam logic [31:0] PC_RESET    = 32'h0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } fetch_state_t;

   function automatic logic is_halt(input logic [31:0] word);
      return word[31:26] == OPCODE_HALT;
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Loader write bus and IF/ID output bundle between fetch stage and its neighbours.
interface instruction_fetch_if #(
   parameter int ADDR_W = 8
) ();
   logic              i_wr_en;
   logic [ADDR_W-1:0] i_wr_addr;
   logic [31:0]       i_wr_data;
   logic [31:0]       o_instr;
   logic [31:0]       o_pc_plus4;
   logic              o_valid;

   modport master (
      output i_wr_en, i_wr_addr, i_wr_data,
      input  o_instr, o_pc_plus4, o_valid
   );

   modport slave (
      input  i_wr_en, i_wr_addr, i_wr_data,
      output o_instr, o_pc_plus4, o_valid
   );
endinterface

// File: rtl/instruction_fetch_mem.sv
// Word-addressed instruction store: synchronous write, combinational read, no reset.
module instruction_memory #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [31:0]       i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [31:0]       o_rdata
);
   logic [31:0] r_mem [MEM_DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, instruction memory, IF/ID register, stall/redirect/HALT handling.
// Optional single-step gating of fetch when FETCH_STEP_EN is defined.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
`ifdef FETCH_STEP_EN
   input  logic                i_step,
`endif
   input  logic                i_stall,
   input  logic                i_pc_modify,
   input  logic [31:0]         i_pc_target,
   instruction_fetch_if.slave  bus,
   output logic [31:0]         o_pc,
   output logic                o_halted
);
   fetch_state_t r_state, w_state_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   logic [31:0]  r_instr, w_instr_nxt;
   logic [31:0]  r_pc4, w_pc4_nxt;
   logic         r_valid, w_valid_nxt;
   logic         w_mem_we;
   logic         w_advance;
   logic [31:0]  w_rd_data;
   logic [31:0]  w_target;

`ifdef FETCH_STEP_EN
   assign w_advance = ~i_stall & i_step;
`else
   assign w_advance = ~i_stall;
`endif

   assign w_target = i_pc_target & ~32'h3;

   instruction_memory #(
      .MEM_DEPTH(MEM_DEPTH),
      .ADDR_W   (ADDR_W)
   ) u_imem (
      .i_clk  (i_clk),
      .i_we   (w_mem_we),
      .i_waddr(bus.i_wr_addr),
      .i_wdata(bus.i_wr_data),
      .i_raddr(r_pc[ADDR_W+1:2]),
      .o_rdata(w_rd_data)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_pc    <= PC_RESET;
         r_instr <= INSTR_NOP;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_instr <= w_instr_nxt;
         r_pc4   <= w_pc4_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      w_pc4_nxt   = r_pc4;
      w_valid_nxt = r_valid;
      w_mem_we    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_mem_we = bus.i_wr_en;
            if (i_start) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (i_pc_modify) begin
               w_pc_nxt    = w_target;
               w_instr_nxt = INSTR_NOP;
               w_valid_nxt = 1'b0;
            end else if (w_advance) begin
               w_instr_nxt = w_rd_data;
               w_pc4_nxt   = r_pc + 32'd4;
               w_valid_nxt = 1'b1;
               // HALT parks PC on its own address so a squash can still redirect cleanly
               if (is_halt(w_rd_data)) w_state_nxt = ST_HALTED;
               else                    w_pc_nxt    = r_pc + 32'd4;
            end
         end
         ST_HALTED: begin
            if (i_pc_modify) begin
               w_pc_nxt    = w_target;
               w_instr_nxt = INSTR_NOP;
               w_valid_nxt = 1'b0;
               w_state_nxt = ST_RUN;
            end else if (!i_stall) begin
               w_instr_nxt = INSTR_NOP;
               w_valid_nxt = 1'b0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.o_instr    = r_instr;
   assign bus.o_pc_plus4 = r_pc4;
   assign bus.o_valid    = r_valid;
   assign o_pc           = r_pc;
   assign o_halted       = (r_state == ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: random stimulus against a rule-level reference model.
module tb_instruction_fetch;
   localparam int DEPTH = 256;
   localparam int AW    = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        halted;
   } snap_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        pc_mod = 1'b0;
   logic        step = 1'b1;
   logic [31:0] tgt = '0;
   logic [31:0] o_pc;
   logic        o_halted;

   int total = 0;
   int bad   = 0;
   snap_t exp_q[$];

   always #5 clk = ~clk;

   instruction_fetch_if #(.ADDR_W(AW)) bus ();

   instruction_fetch #(
      .MEM_DEPTH(DEPTH)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
`ifdef FETCH_STEP_EN
      .i_step     (step),
`endif
      .i_stall    (stall),
      .i_pc_modify(pc_mod),
      .i_pc_target(tgt),
      .bus        (bus),
      .o_pc       (o_pc),
      .o_halted   (o_halted)
   );

   // Reference model: mode 0 = waiting for start, 1 = fetching, 2 = stopped on HALT
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   int          m_mode;

   function automatic snap_t model_snap();
      snap_t s;
      s.pc = m_pc; s.instr = m_instr; s.pc4 = m_pc4;
      s.valid = m_valid; s.halted = (m_mode == 2);
      return s;
   endfunction

   function automatic snap_t dut_snap();
      snap_t s;
      s.pc = o_pc; s.instr = bus.o_instr; s.pc4 = bus.o_pc_plus4;
      s.valid = bus.o_valid; s.halted = o_halted;
      return s;
   endfunction

   task automatic model_reset();
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mode = 0;
   endtask

   task automatic model_step(input bit s, input bit we, input int wa, input logic [31:0] wd,
                             input bit st, input bit md, input logic [31:0] t, input bit sp);
      logic [31:0] w;
      bit go;
`ifdef FETCH_STEP_EN
      go = !st && sp;
`else
      go = !st;
`endif
      if (m_mode == 0) begin
         if (we) m_mem[wa] = wd;
         if (s) m_mode = 1;
      end else if (md) begin
         m_pc = t - (t % 4);
         m_instr = 0; m_valid = 0; m_mode = 1;
      end else if (m_mode == 1 && go) begin
         w = m_mem[(m_pc / 4) % DEPTH];
         m_instr = w; m_pc4 = m_pc + 4; m_valid = 1;
         if ((w >> 26) == 63) m_mode = 2;
         else m_pc = m_pc + 4;
      end else if (m_mode == 2 && !st) begin
         m_instr = 0; m_valid = 0;
      end
   endtask

   task automatic compare(input string name, input snap_t act, input snap_t ex);
      total++;
      if (act !== ex) begin
         bad++;
         $display("FAIL %s t=%0t got pc=%h instr=%h pc4=%h v=%b h=%b want pc=%h instr=%h pc4=%h v=%b h=%b",
                  name, $time, act.pc, act.instr, act.pc4, act.valid, act.halted,
                  ex.pc, ex.instr, ex.pc4, ex.valid, ex.halted);
      end
   endtask

   // Called at posedge+1; applies inputs for the next edge and queues the expected result
   task automatic cycle(input bit s, input bit we, input int wa, input logic [31:0] wd,
                        input bit st, input bit md, input logic [31:0] t, input bit sp);
      start = s; bus.i_wr_en = we; bus.i_wr_addr = AW'(wa); bus.i_wr_data = wd;
      stall = st; pc_mod = md; tgt = t; step = sp;
      model_step(s, we, wa, wd, st, md, t, sp);
      @(posedge clk);
      exp_q.push_back(model_snap());
      #1;
   endtask

   task automatic idle_cycle(input bit sp);
      cycle(0, 0, 0, 0, 0, 0, 0, sp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare("async_reset", dut_snap(), model_snap());
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      snap_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare("cycle", dut_snap(), e);
         end
      end
   end

   initial begin : driver
      logic [31:0] w;
      bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
      model_reset();
      #12;
      compare("reset_state", dut_snap(), model_snap());
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) begin
         w = $urandom;
         if ($urandom_range(15) == 0) w[31:26] = 6'b111111;
         else if (w[31:26] == 6'b111111) w[31:26] = 6'b001000;
         if (i == 0) w = 32'h2001_0001;
         if (i == 1) w = 32'h2002_0002;
         if (i == 2) w = 32'hFC00_0000;
         cycle(0, 1, i, w, 0, 0, 0, 1);
      end

      // ADDI, ADDI, HALT then parked at PC 8
      cycle(1, 0, 0, 0, 0, 0, 0, 1);
      repeat (5) idle_cycle(1);

      // redirect with simultaneous stall from HALTED, target 0x43 -> 0x40
      cycle(0, 0, 0, 0, 1, 1, 32'h43, 1);
      repeat (3) idle_cycle(1);

      // loader write while running must be ignored, then revisit index 5
      cycle(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1, 32'h14, 1);
      idle_cycle(1);
      repeat (3) cycle(0, 0, 0, 0, 1, 0, 0, 1);
      repeat (2) idle_cycle(1);
`ifdef FETCH_STEP_EN
      repeat (3) idle_cycle(0);
      idle_cycle(1);
      idle_cycle(0);
`endif

      // PC+4 wraparound near the top of the address space
      cycle(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
      repeat (2) idle_cycle(1);

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] t;
         w = $urandom;
         if ($urandom_range(7) != 0 && w[31:26] == 6'b111111) w[31:26] = 6'b000000;
         t = $urandom;
         if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
         if ($urandom_range(249) == 0) do_reset();
         cycle($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom_range(DEPTH - 1), w,
               $urandom_range(9) < 3, $urandom_range(19) < 3, t, $urandom_range(1) == 1);
      end

      do_reset();
      repeat (2) idle_cycle(1);

      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
      #7;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
